// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per clock.
// A single borrow flip-flop feeds a full-subtractor cell; operands load on start, result is parallel.
module serial_sub #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow_out,
  output logic         overflow
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_a_sh;
  logic [W-1:0]   r_b_sh;
  logic [W-1:0]   r_diff;
  logic [CW-1:0]  r_count;
  logic           r_bw;
  logic           r_a_msb;
  logic           r_b_msb;
  logic           r_busy;
  logic           r_done;
  logic           r_borrow_out;
  logic           r_overflow;

  logic w_x;
  logic w_y;
  logic w_d;
  logic w_bw_next;
  logic w_last;

  // Full-subtractor cell on the current LSBs and the running borrow.
  assign w_x       = r_a_sh[0];
  assign w_y       = r_b_sh[0];
  assign w_d       = w_x ^ w_y ^ r_bw;
  assign w_bw_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_bw);
  assign w_last    = (r_count == CW'(W - 1));

  // NOTE: every register, datapath included, is cleared by reset so an aborted
  // operation leaves nothing behind; all sequential updates use non-blocking <=.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_diff       <= '0;
      r_count      <= '0;
      r_bw         <= 1'b0;
      r_a_msb      <= 1'b0;
      r_b_msb      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_borrow_out <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sh       <= a;
            r_b_sh       <= b;
            r_a_msb      <= a[W-1];
            r_b_msb      <= b[W-1];
            r_bw         <= 1'b0;
            r_count      <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end

        RUN: begin
          // start is deliberately ignored here; operands stay as loaded.
          r_diff  <= {w_d, r_diff[W-1:1]};
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_bw    <= w_bw_next;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_borrow_out <= w_bw_next;
            r_overflow   <= (r_a_msb != r_b_msb) & (w_d != r_a_msb);
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= DONE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed cases, random W=8 operations and an
// exhaustive W=4 sweep, all compared against an arithmetic reference model.
module tb_serial_sub;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, borrow8, ovf8;
  logic [7:0] diff8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, borrow4, ovf4;
  logic [3:0] diff4;

  int checks = 0;
  int errors = 0;

  serial_sub #(.W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8), .overflow(ovf8)
  );

  serial_sub #(.W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4), .overflow(ovf4)
  );

  // Reference: {diff, borrow, overflow} from integer arithmetic on w-bit operands.
  function automatic int ref_model(input int w, input int x, input int y);
    int m, sx, sy, r, d, bo, ov;
    m  = 1 << w;
    d  = (x - y + m) % m;
    bo = (x < y) ? 1 : 0;
    sx = (x >= m / 2) ? x - m : x;
    sy = (y >= m / 2) ? y - m : y;
    r  = sx - sy;
    ov = (r > m / 2 - 1 || r < -(m / 2)) ? 1 : 0;
    return (d << 2) | (bo << 1) | ov;
  endfunction

  // Drive one W=8 operation. lat counts negedges from the accept edge until done is seen.
  // b2b: caller is already at the done-cycle negedge, so start is raised immediately.
  // poke_at: RUN sample index at which a spurious start with (1,1) is pulsed.
  task automatic op8(input logic [7:0] xa, input logic [7:0] xb, input bit b2b,
                     input int poke_at, output int lat, output int busy_cycles,
                     output logic [9:0] at_accept);
    if (!b2b) @(negedge clk);
    a8 = xa; b8 = xb; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = $urandom; b8 = $urandom;
    lat = 1; busy_cycles = 0;
    at_accept = {diff8, borrow8, ovf8};
    while (!done8 && lat < 40) begin
      if (busy8) busy_cycles++;
      if (lat == poke_at) begin a8 = 8'd1; b8 = 8'd1; start8 = 1'b1; end
      @(negedge clk);
      start8 = 1'b0;
      lat++;
    end
  endtask

  task automatic op4(input logic [3:0] xa, input logic [3:0] xb, output int lat);
    @(negedge clk);
    a4 = xa; b4 = xb; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; a4 = $urandom; b4 = $urandom;
    lat = 1;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy8, done8, diff8, borrow8, ovf8} !== 12'h000) begin
      errors++;
      $display("FAIL reset_w8: got busy=%b done=%b diff=%h bo=%b ov=%b, want all 0",
               busy8, done8, diff8, borrow8, ovf8);
    end
    checks++;
    if ({busy4, done4, diff4, borrow4, ovf4} !== 8'h00) begin
      errors++;
      $display("FAIL reset_w4: got busy=%b done=%b diff=%h bo=%b ov=%b, want all 0",
               busy4, done4, diff4, borrow4, ovf4);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [7:0] va [5] = '{8'd5, 8'd3, 8'h80, 8'h7F, 8'd0};
    logic [7:0] vb [5] = '{8'd3, 8'd5, 8'h01, 8'hFF, 8'd0};
    int lat, bc, exp;
    logic [9:0] acc;
    for (int i = 0; i < 5; i++) begin
      op8(va[i], vb[i], 1'b0, 0, lat, bc, acc);
      exp = ref_model(8, int'(va[i]), int'(vb[i]));
      checks++;
      if (lat !== 9 || bc !== 8) begin
        errors++;
        $display("FAIL timing_%0d: got latency=%0d busy=%0d, want latency=9 busy=8", i, lat, bc);
      end
      checks++;
      if ({diff8, borrow8, ovf8} !== exp[9:0]) begin
        errors++;
        $display("FAIL vector_%0d: a=%h b=%h got diff=%h bo=%b ov=%b, want diff=%h bo=%b ov=%b",
                 i, va[i], vb[i], diff8, borrow8, ovf8, exp[9:2], exp[1], exp[0]);
      end
      @(negedge clk);
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || {diff8, borrow8, ovf8} !== exp[9:0]) begin
        errors++;
        $display("FAIL hold_%0d: got done=%b busy=%b diff=%h, want done=0 busy=0 diff=%h",
                 i, done8, busy8, diff8, exp[9:2]);
      end
    end
  endtask

  task automatic test_random();
    int lat, bc, exp;
    logic [9:0] acc;
    logic [7:0] xa, xb;
    for (int i = 0; i < 40; i++) begin
      xa = 8'($urandom);
      xb = 8'($urandom);
      op8(xa, xb, 1'b0, 0, lat, bc, acc);
      exp = ref_model(8, int'(xa), int'(xb));
      checks++;
      if (lat !== 9 || {diff8, borrow8, ovf8} !== exp[9:0]) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h got lat=%0d diff=%h bo=%b ov=%b, want lat=9 diff=%h bo=%b ov=%b",
                 i, xa, xb, lat, diff8, borrow8, ovf8, exp[9:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [9:0] acc;
    op8(8'd9, 8'd4, 1'b0, 3, lat, bc, acc);
    checks++;
    if (lat !== 9 || diff8 !== 8'd5 || borrow8 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: got lat=%0d diff=%h bo=%b, want lat=9 diff=05 bo=0", lat, diff8, borrow8);
    end
    checks++;
    if (done8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: got done=%b, want 1", done8);
    end
    op8(8'hFF, 8'h01, 1'b1, 0, lat, bc, acc);
    checks++;
    if (acc !== 10'h000) begin
      errors++;
      $display("FAIL b2b_clear: got {diff,bo,ov}=%h after accept, want 000", acc);
    end
    checks++;
    if (lat !== 9 || bc !== 8 || {diff8, borrow8, ovf8} !== {8'hFE, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_result: got lat=%0d busy=%0d diff=%h bo=%b ov=%b, want lat=9 busy=8 diff=fe bo=0 ov=0",
               lat, bc, diff8, borrow8, ovf8);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc;
    logic [9:0] acc;
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy8, done8, diff8, borrow8, ovf8} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_run: got busy=%b done=%b diff=%h bo=%b ov=%b, want all 0",
               busy8, done8, diff8, borrow8, ovf8);
    end
    reset = 1'b1;
    op8(8'd10, 8'd10, 1'b0, 0, lat, bc, acc);
    checks++;
    if (lat !== 9 || {diff8, borrow8, ovf8} !== 10'h000) begin
      errors++;
      $display("FAIL after_reset: got lat=%0d diff=%h bo=%b ov=%b, want lat=9 diff=00 bo=0 ov=0",
               lat, diff8, borrow8, ovf8);
    end
  endtask

  task automatic test_sweep_w4();
    int lat, exp;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        op4(4'(x), 4'(y), lat);
        exp = ref_model(4, x, y);
        checks++;
        if (lat !== 5 || {diff4, borrow4, ovf4} !== exp[5:0]) begin
          errors++;
          $display("FAIL sweep_w4: a=%0d b=%0d got lat=%0d diff=%h bo=%b ov=%b, want lat=5 diff=%h bo=%b ov=%b",
                   x, y, lat, diff4, borrow4, ovf4, exp[5:2], exp[1], exp[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep_w4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
